shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: CLK and RESET.
REQ-002 The block SHALL have these ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous active-high reset
- START  input  1  shift request from the control unit
- OPCODE  input  3  001 LSL, 010 LSR, 011 ASR, 100 ROR; 000/101/110/111 invalid
- DATA_IN  input  8  operand to shift
- AMOUNT  input  8  unsigned shift amount
- RESULT  output  8  shifted value, registered
- DONE  output  1  one-cycle completion pulse, registered
- BUSYWAIT  output  1  stall request to the PC/control unit

Function
REQ-003 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-004 IDLE SHALL accept a request when START=1 and OPCODE is valid; invalid opcodes SHALL be ignored with BUSYWAIT=0 and no state change.
REQ-005 On the accepting edge, the block SHALL capture DATA_IN and OPCODE and load the counter CNT with the effective amount (REQ-013/014).
REQ-006 After acceptance the block SHALL go to SHIFT if CNT!=0, else to DONE with RESULT=DATA_IN.
REQ-007 In SHIFT, each edge SHALL shift the working value by one bit and decrement CNT:
- LSL: zero fill at bit 0.
- LSR: zero fill at bit 7.
- ASR: bit 7 replicated.
- ROR: bit 0 rotates into bit 7.
REQ-008 When CNT==1 in SHIFT, the block SHALL perform the last shift, update RESULT and go to DONE, so an amount N takes exactly N SHIFT cycles.
REQ-009 DONE SHALL last exactly one cycle with DONE=1, then return to IDLE unconditionally; START during DONE SHALL be ignored.
REQ-010 BUSYWAIT SHALL be combinational:
- 1 in IDLE when START=1 and OPCODE is valid.
- 1 throughout SHIFT.
- 0 in DONE and otherwise.
- Total stall for amount N is N+1 cycles.
REQ-011 START and operand changes during SHIFT SHALL be ignored; the captured operands govern the operation.
REQ-012 RESULT SHALL hold its last value in IDLE until the next accepted request updates it.

Reset
REQ-015 On RESET=1, the block SHALL immediately, without a clock edge, enter IDLE with RESULT=8'h00, DONE=0, CNT=0 and BUSYWAIT=0.
REQ-016 RESET asserted mid-SHIFT SHALL abort the operation with no DONE pulse; after RESET deasserts, the next valid START SHALL start a fresh operation.

Configuration
REQ-013 Without SHIFT_SATURATE_EN, the effective amount SHALL be AMOUNT[2:0] (modulo 8) for all opcodes.
REQ-014 With SHIFT_SATURATE_EN defined:
- AMOUNT>=8 on LSL/LSR SHALL produce 8'h00.
- AMOUNT>=8 on ASR SHALL produce {8{DATA_IN[7]}}.
- Each saturated case SHALL use exactly one SHIFT cycle.
- ROR SHALL remain modulo 8.
- AMOUNT<8 SHALL behave as without the macro.

Verification
REQ-017 LSL, DATA_IN=8'h81, AMOUNT=1 -> BUSYWAIT high for 2 cycles, DONE pulse at the 2nd edge after accept cycle start, RESULT=8'h02.
REQ-018 ASR, DATA_IN=8'h80, AMOUNT=3 -> BUSYWAIT high for 4 cycles, RESULT=8'hF0, one DONE pulse; ROR, DATA_IN=8'h01, AMOUNT=1 -> RESULT=8'h80.
REQ-019 AMOUNT=0, LSR, DATA_IN=8'h5A -> BUSYWAIT high for 1 cycle, next state DONE, RESULT=8'h5A; OPCODE=3'b111 with START=1 -> BUSYWAIT=0, no DONE.
REQ-020 LSR, DATA_IN=8'hFF, AMOUNT=10 -> with SHIFT_SATURATE_EN, RESULT=8'h00 after 1 SHIFT cycle; without the macro, RESULT=8'h3F after 2 SHIFT cycles.
REQ-021 RESET pulsed during the 2nd SHIFT cycle of LSL by 5 -> RESULT=8'h00 and BUSYWAIT=0 immediately, no DONE pulse; a subsequent LSL 8'h01 by 2 -> RESULT=8'h04.

Source files
------------

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle barrel-less shifter for a simple control unit. A request is
// accepted in IDLE, the operand is shifted one bit per clock in SHIFT, and
// DONE pulses for a single cycle when the result is available. BUSYWAIT
// stalls the PC/control unit from the accepting cycle through the last
// SHIFT cycle (N+1 cycles for an amount of N).
//
// Ports:
//   CLK       in   1  rising-edge clock
//   RESET     in   1  asynchronous active-high reset
//   START     in   1  shift request
//   OPCODE    in   3  001 LSL, 010 LSR, 011 ASR, 100 ROR; others invalid
//   DATA_IN   in   8  operand to shift
//   AMOUNT    in   8  unsigned shift amount
//   RESULT    out  8  shifted value, registered, held until the next request
//   DONE      out  1  one-cycle completion pulse, registered
//   BUSYWAIT  out  1  combinational stall request
//
// Configuration:
//   SHIFT_SATURATE_EN  when defined, AMOUNT >= 8 on LSL/LSR yields 8'h00 and
//                      on ASR yields the sign fill, each in one SHIFT cycle.
//                      ROR stays modulo 8. When undefined, every opcode uses
//                      AMOUNT modulo 8.
// -----------------------------------------------------------------------------
module shift_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] OPCODE,
  input  logic [7:0] DATA_IN,
  input  logic [7:0] AMOUNT,
  output logic [7:0] RESULT,
  output logic       DONE,
  output logic       BUSYWAIT
);

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       opcode_valid;
  logic       accept;
  logic [2:0] eff_cnt;
  logic       eff_sat;

  logic [7:0] work;      // working value, kept apart so RESULT only changes at completion
  logic [2:0] op_q;      // opcode captured at acceptance
  logic [2:0] cnt;       // remaining SHIFT cycles
  logic       sat_q;     // saturated operation: single SHIFT cycle produces the fill value
  logic [7:0] step;      // working value after one more shift

  assign opcode_valid = (OPCODE == OP_LSL) || (OPCODE == OP_LSR) ||
                        (OPCODE == OP_ASR) || (OPCODE == OP_ROR);
  assign accept       = (state == ST_IDLE) && START && opcode_valid;

  // Effective shift count loaded at acceptance.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    eff_cnt = 3'(AMOUNT % 8'd8);
    eff_sat = 1'b0;
`ifdef SHIFT_SATURATE_EN
    // Any shift of 8 or more fully drains the operand, so one cycle suffices.
    if ((AMOUNT >= 8'd8) && (OPCODE != OP_ROR)) begin
      eff_cnt = 3'd1;
      eff_sat = 1'b1;
    end
`endif
  end

  // One-bit shift of the working value, or the saturation fill.
  always_comb begin
    step = work;
    if (sat_q) begin
      case (op_q)
        OP_LSL, OP_LSR: step = 8'h00;
        OP_ASR:         step = {8{work[7]}};
        default:        step = work;
      endcase
    end else begin
      case (op_q)
        OP_LSL:  step = {work[6:0], 1'b0};
        OP_LSR:  step = {1'b0, work[7:1]};
        OP_ASR:  step = {work[7], work[7:1]};
        OP_ROR:  step = {work[0], work[7:1]};
        default: step = work;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and stall logic.
  always_comb begin
    state_next = state;
    BUSYWAIT   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          BUSYWAIT   = 1'b1;
          state_next = (eff_cnt == 3'd0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        BUSYWAIT = 1'b1;
        if (cnt == 3'd1) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Reset releases the stall at once, even while START is still asserted.
    if (RESET) BUSYWAIT = 1'b0;
  end

  // Datapath: operand capture, shifting, result and completion pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      work   <= 8'h00;
      op_q   <= 3'b000;
      cnt    <= 3'd0;
      sat_q  <= 1'b0;
      RESULT <= 8'h00;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            work  <= DATA_IN;
            op_q  <= OPCODE;
            cnt   <= eff_cnt;
            sat_q <= eff_sat;
            // A zero amount completes without visiting SHIFT.
            if (eff_cnt == 3'd0) begin
              RESULT <= DATA_IN;
              DONE   <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work <= step;
          cnt  <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            RESULT <= step;
            DONE   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed self-checking bench for shift_sequencer. Each scenario task drives
// its own stimulus and compares outputs against hand-computed values. Inputs
// change one time unit after the rising edge; outputs are sampled two time
// units after it.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [2:0] OPCODE;
  logic [7:0] DATA_IN;
  logic [7:0] AMOUNT;
  logic [7:0] RESULT;
  logic       DONE;
  logic       BUSYWAIT;

  int errors = 0;
  int checks = 0;

  shift_sequencer dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .OPCODE   (OPCODE),
    .DATA_IN  (DATA_IN),
    .AMOUNT   (AMOUNT),
    .RESULT   (RESULT),
    .DONE     (DONE),
    .BUSYWAIT (BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Issues one request starting at edge+1 and observes 12 further cycles.
  // Operands and opcode are scrambled after the accepting edge so only the
  // captured values can produce the right result.
  task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a,
                       output int busy, output int done_at, output int pulses,
                       output logic [7:0] res);
    busy    = 0;
    done_at = -1;
    pulses  = 0;
    START   = 1'b1;
    OPCODE  = op;
    DATA_IN = d;
    AMOUNT  = a;
    #1;
    if (BUSYWAIT === 1'b1) busy++;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK);
      #1;
      START   = 1'b0;
      OPCODE  = 3'b011;
      DATA_IN = ~d;
      AMOUNT  = a + 8'd5;
      #1;
      if (BUSYWAIT === 1'b1) busy++;
      if (DONE === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
    end
    res = RESULT;
  endtask

  task automatic test_reset();
    RESET   = 1'b1;
    START   = 1'b1;
    OPCODE  = OP_LSL;
    DATA_IN = 8'hAA;
    AMOUNT  = 8'd3;
    #2;
    checks++;
    if (RESULT !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", RESULT); end
    checks++;
    if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b want 0", BUSYWAIT); end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    START = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0 || DONE !== 1'b0 || RESULT !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b done=%b result=%h want 0 0 00", BUSYWAIT, DONE, RESULT);
    end
  endtask

  task automatic test_lsl();
    int busy, done_at, pulses;
    logic [7:0] res;
    issue(OP_LSL, 8'h81, 8'd1, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h02) begin errors++; $display("FAIL lsl1_result: got %h want 02", res); end
    checks++;
    if (busy !== 2) begin errors++; $display("FAIL lsl1_busy: got %0d want 2", busy); end
    checks++;
    if (done_at !== 2 || pulses !== 1) begin
      errors++; $display("FAIL lsl1_done: at %0d x%0d want at 2 x1", done_at, pulses);
    end
    issue(OP_LSL, 8'hFF, 8'd7, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h80 || busy !== 8 || done_at !== 8) begin
      errors++; $display("FAIL lsl7: result %h busy %0d done_at %0d want 80 8 8", res, busy, done_at);
    end
  endtask

  task automatic test_asr();
    int busy, done_at, pulses;
    logic [7:0] res;
    issue(OP_ASR, 8'h80, 8'd3, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'hF0) begin errors++; $display("FAIL asr3_result: got %h want F0", res); end
    checks++;
    if (busy !== 4) begin errors++; $display("FAIL asr3_busy: got %0d want 4", busy); end
    checks++;
    if (done_at !== 4 || pulses !== 1) begin
      errors++; $display("FAIL asr3_done: at %0d x%0d want at 4 x1", done_at, pulses);
    end
    issue(OP_ASR, 8'h7F, 8'd2, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h1F || busy !== 3) begin
      errors++; $display("FAIL asr_pos: result %h busy %0d want 1F 3", res, busy);
    end
  endtask

  task automatic test_ror();
    int busy, done_at, pulses;
    logic [7:0] res;
    issue(OP_ROR, 8'h01, 8'd1, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h80 || busy !== 2) begin
      errors++; $display("FAIL ror1: result %h busy %0d want 80 2", res, busy);
    end
    // 12 mod 8 = 4 in both builds; 1001_0110 rotated right 4 -> 0110_1001.
    issue(OP_ROR, 8'h96, 8'd12, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h69 || busy !== 5 || done_at !== 5) begin
      errors++; $display("FAIL ror12: result %h busy %0d done_at %0d want 69 5 5", res, busy, done_at);
    end
  endtask

  task automatic test_zero_amount();
    int busy, done_at, pulses;
    logic [7:0] res;
    issue(OP_LSR, 8'h5A, 8'd0, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h5A) begin errors++; $display("FAIL zero_result: got %h want 5A", res); end
    checks++;
    if (busy !== 1) begin errors++; $display("FAIL zero_busy: got %0d want 1", busy); end
    checks++;
    if (done_at !== 1 || pulses !== 1) begin
      errors++; $display("FAIL zero_done: at %0d x%0d want at 1 x1", done_at, pulses);
    end
  endtask

  // Runs after test_zero_amount, so RESULT must still read 5A.
  task automatic test_invalid();
    int busy, pulses;
    busy    = 0;
    pulses  = 0;
    START   = 1'b1;
    OPCODE  = 3'b111;
    DATA_IN = 8'h33;
    AMOUNT  = 8'd2;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL invalid_busy_comb: got %b want 0", BUSYWAIT); end
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
      OPCODE = (c < 2) ? 3'b111 : 3'b000;
      #1;
      if (BUSYWAIT === 1'b1) busy++;
      if (DONE === 1'b1) pulses++;
    end
    START = 1'b0;
    checks++;
    if (busy !== 0 || pulses !== 0) begin
      errors++; $display("FAIL invalid_ignored: busy %0d done %0d want 0 0", busy, pulses);
    end
    checks++;
    if (RESULT !== 8'h5A) begin errors++; $display("FAIL result_hold: got %h want 5A", RESULT); end
  endtask

  task automatic test_large_amount();
    int busy, done_at, pulses;
    logic [7:0] res;
    issue(OP_LSR, 8'hFF, 8'd10, busy, done_at, pulses, res);
`ifdef SHIFT_SATURATE_EN
    checks++;
    if (res !== 8'h00 || busy !== 2 || done_at !== 2) begin
      errors++; $display("FAIL lsr10: result %h busy %0d done_at %0d want 00 2 2", res, busy, done_at);
    end
    issue(OP_ASR, 8'h80, 8'd9, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'hFF || busy !== 2) begin
      errors++; $display("FAIL asr9: result %h busy %0d want FF 2", res, busy);
    end
    issue(OP_LSL, 8'h01, 8'd8, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h00 || busy !== 2) begin
      errors++; $display("FAIL lsl8: result %h busy %0d want 00 2", res, busy);
    end
`else
    checks++;
    if (res !== 8'h3F || busy !== 3 || done_at !== 3) begin
      errors++; $display("FAIL lsr10: result %h busy %0d done_at %0d want 3F 3 3", res, busy, done_at);
    end
    issue(OP_ASR, 8'h80, 8'd9, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'hC0 || busy !== 2) begin
      errors++; $display("FAIL asr9: result %h busy %0d want C0 2", res, busy);
    end
    issue(OP_LSL, 8'h01, 8'd8, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h01 || busy !== 1) begin
      errors++; $display("FAIL lsl8: result %h busy %0d want 01 1", res, busy);
    end
`endif
  endtask

  // START held high: ignored in SHIFT and DONE, accepted again once IDLE.
  task automatic test_back_to_back();
    START   = 1'b1;
    OPCODE  = OP_LSL;
    DATA_IN = 8'h03;
    AMOUNT  = 8'd1;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", BUSYWAIT); end
    @(posedge CLK); #1;
    checks++;
    if (BUSYWAIT !== 1'b1 || DONE !== 1'b0) begin
      errors++; $display("FAIL b2b_shift: busy %b done %b want 1 0", BUSYWAIT, DONE);
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b1 || BUSYWAIT !== 1'b0 || RESULT !== 8'h06) begin
      errors++; $display("FAIL b2b_done1: done %b busy %b result %h want 1 0 06", DONE, BUSYWAIT, RESULT);
    end
    OPCODE  = OP_LSR;
    DATA_IN = 8'h10;
    AMOUNT  = 8'd2;
    @(posedge CLK); #1;
    checks++;
    if (BUSYWAIT !== 1'b1 || DONE !== 1'b0) begin
      errors++; $display("FAIL b2b_reaccept: busy %b done %b want 1 0", BUSYWAIT, DONE);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b0 || BUSYWAIT !== 1'b1) begin
      errors++; $display("FAIL b2b_shift2: done %b busy %b want 0 1", DONE, BUSYWAIT);
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b1 || RESULT !== 8'h04) begin
      errors++; $display("FAIL b2b_done2: done %b result %h want 1 04", DONE, RESULT);
    end
    @(posedge CLK); #1;
  endtask

  // Entered with RESULT = 04, so the asynchronous clear is observable.
  task automatic test_reset_mid_shift();
    int busy, done_at, pulses;
    logic [7:0] res;
    START   = 1'b1;
    OPCODE  = OP_LSL;
    DATA_IN = 8'h01;
    AMOUNT  = 8'd5;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    checks++;
    if (RESULT !== 8'h00 || BUSYWAIT !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL mid_reset: result %h busy %b done %b want 00 0 0", RESULT, BUSYWAIT, DONE);
    end
    @(posedge CLK); #1;
    RESET  = 1'b0;
    pulses = 0;
    busy   = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) pulses++;
      if (BUSYWAIT === 1'b1) busy++;
    end
    checks++;
    if (pulses !== 0 || busy !== 0) begin
      errors++; $display("FAIL abort_no_done: done %0d busy %0d want 0 0", pulses, busy);
    end
    issue(OP_LSL, 8'h01, 8'd2, busy, done_at, pulses, res);
    checks++;
    if (res !== 8'h04 || busy !== 3 || done_at !== 3 || pulses !== 1) begin
      errors++;
      $display("FAIL after_reset_op: result %h busy %0d done_at %0d x%0d want 04 3 3 x1", res, busy, done_at, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_asr();
    test_ror();
    test_zero_amount();
    test_invalid();
    test_large_amount();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
